matrix_scan_serializer: RTL and testbench

MATRIX_SCAN_SERIALIZER -- requirements
Module: matrix_scan_serializer

---
 rtl/matrix_scan_pkg.sv | 13 +
 rtl/matrix_peak_tracker.sv | 59 +++++
 rtl/matrix_scan_serializer.sv | 113 +++++++++++
 tb/tb_matrix_scan_serializer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_scan_pkg.sv
// Shared constants and the scan FSM state type for the matrix scan serializer.
package matrix_scan_pkg;
  localparam int MA_SIZE_DEF = 4;
  localparam int CNT_W_DEF   = 9;
  localparam int N_DEF       = MA_SIZE_DEF * MA_SIZE_DEF;
  localparam int IDX_W_DEF   = $clog2(N_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } scan_state_t;
endpackage

// File: rtl/matrix_peak_tracker.sv
// Running max/argmax over the beats of one scan; ties keep the lowest index.
module matrix_peak_tracker
  import matrix_scan_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             abort,
  input  logic             upd,
  input  logic             fin,
  input  logic [CNT_W-1:0] data,
  input  logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] peak_val,
  output logic [IDX_W-1:0] peak_idx,
  output logic             peak_valid
);
  logic [CNT_W-1:0] max_q, max_d;
  logic [IDX_W-1:0] arg_q, arg_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      arg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      max_q   <= max_d;
      arg_q   <= arg_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    max_d   = max_q;
    arg_d   = arg_q;
    valid_d = valid_q;
    if (clear) begin
      max_d   = '0;
      arg_d   = '0;
      valid_d = 1'b0;
    end else if (abort) begin
      valid_d = 1'b0;
    end else begin
      // Strict compare: an equal later value never displaces the earlier index.
      if (upd && (data > max_q)) begin
        max_d = data;
        arg_d = idx;
      end
      if (fin) valid_d = 1'b1;
    end
  end

  assign peak_val   = max_q;
  assign peak_idx   = arg_q;
  assign peak_valid = valid_q;
endmodule

// File: rtl/matrix_scan_serializer.sv
// Snapshots an MA_SIZE x MA_SIZE counter matrix and streams it out with valid/ready.
// Optional peak tracking is enabled by defining MATRIX_SCAN_PEAK_EN.
module matrix_scan_serializer
  import matrix_scan_pkg::*;
#(
  parameter int MA_SIZE = MA_SIZE_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IDX_W   = $clog2(MA_SIZE * MA_SIZE)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [MA_SIZE*MA_SIZE*CNT_W-1:0]   matrix_in,
  input  logic                               start,
  input  logic                               flush,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [CNT_W-1:0]                   out_data,
  output logic [IDX_W-1:0]                   out_idx,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic [CNT_W-1:0]                   peak_val,
  output logic [IDX_W-1:0]                   peak_idx,
  output logic                               peak_valid
);
  localparam int N = MA_SIZE * MA_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N*CNT_W-1:0] snap_q, snap_d;
  logic start_acc, xfer, last_xfer;

  // Flush wins over both a new start and a pending transfer.
  assign start_acc = (state_q == IDLE) && start && !flush;
  assign xfer      = (state_q == STREAM) && out_ready && !flush;
  assign last_xfer = xfer && (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = STREAM;
        STREAM:  if (last_xfer) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    snap_d = snap_q;
    idx_d  = idx_q;
    if (start_acc) begin
      snap_d = matrix_in;
      idx_d  = '0;
    end else if (xfer) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    if (state_q == STREAM) begin
      out_valid = 1'b1;
      out_data  = snap_q[int'(idx_q)*CNT_W +: CNT_W];
      out_idx   = idx_q;
      out_last  = (idx_q == LAST_IDX);
    end
  end

`ifdef MATRIX_SCAN_PEAK_EN
  matrix_peak_tracker #(
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) u_peak (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc),
    .abort     (flush),
    .upd       (xfer),
    .fin       (last_xfer),
    .data      (out_data),
    .idx       (idx_q),
    .peak_val  (peak_val),
    .peak_idx  (peak_idx),
    .peak_valid(peak_valid)
  );
`else
  assign peak_val   = '0;
  assign peak_idx   = '0;
  assign peak_valid = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_scan_serializer.sv
// Randomized bench for matrix_scan_serializer against a cycle-level behavioural model.
module tb_matrix_scan_serializer;
  import matrix_scan_pkg::*;

  localparam int N  = N_DEF;
  localparam int CW = CNT_W_DEF;
  localparam int IW = IDX_W_DEF;
`ifdef MATRIX_SCAN_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, flush, out_ready;
  logic [N*CW-1:0] matrix_in;
  logic          out_valid, out_last, busy, done, peak_valid;
  logic [CW-1:0] out_data, peak_val;
  logic [IW-1:0] out_idx, peak_idx;

  matrix_scan_serializer dut (
    .clk(clk), .rst(rst), .matrix_in(matrix_in), .start(start), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done), .peak_val(peak_val),
    .peak_idx(peak_idx), .peak_valid(peak_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: streaming flag + position, one-cycle done flag, and a frozen copy of the matrix.
  bit          m_stream, m_done, m_pv;
  int          m_pos;
  int unsigned m_snap [N];
  int unsigned m_pval;
  int          m_pidx;
  int unsigned vals [N];
  int unsigned beats [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < N; k++) matrix_in[k*CW +: CW] = CW'(vals[k]);
  endtask

  task automatic model_reset();
    m_stream = 0; m_done = 0; m_pv = 0; m_pos = 0; m_pval = 0; m_pidx = 0;
    for (int k = 0; k < N; k++) m_snap[k] = 0;
  endtask

  task automatic model_step();
    if (rst) model_reset();
    else if (flush) begin
      m_stream = 0; m_done = 0; m_pv = 0;
    end else if (m_done) m_done = 0;
    else if (m_stream) begin
      if (out_ready) begin
        if (m_pos == N - 1) begin
          m_stream = 0; m_done = 1; m_pv = 1;
          m_pval = m_snap[0]; m_pidx = 0;
          for (int k = 1; k < N; k++)
            if (m_snap[k] > m_pval) begin m_pval = m_snap[k]; m_pidx = k; end
        end else m_pos++;
      end
    end else if (start) begin
      for (int k = 0; k < N; k++) m_snap[k] = matrix_in[k*CW +: CW];
      m_pos = 0; m_stream = 1; m_pv = 0;
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, m_stream);
    chk("out_last", out_last, (m_stream && m_pos == N - 1));
    chk("busy", busy, (m_stream || m_done));
    chk("done", done, m_done);
    if (m_stream) begin
      chk("out_data", out_data, m_snap[m_pos]);
      chk("out_idx", out_idx, m_pos);
    end
    chk("peak_valid", peak_valid, PEAK && m_pv);
    if (!PEAK) begin
      chk("peak_val_tied", peak_val, 0);
      chk("peak_idx_tied", peak_idx, 0);
    end else if (m_pv) begin
      chk("peak_val", peak_val, m_pval);
      chk("peak_idx", peak_idx, m_pidx);
    end
  endtask

  task automatic tick();
    if (out_valid === 1'b1 && out_ready) beats.push_back(out_data);
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_idx"}, out_idx, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pval"}, peak_val, 0);
    chk({tag, "_pidx"}, peak_idx, 0);
    chk({tag, "_pvalid"}, peak_valid, 0);
  endtask

  task automatic pulse_start();
    beats.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin tick(); n++; end
    chk("done_seen", done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; out_ready = 1'b0; matrix_in = '0;
    #1;
    model_reset();
    check_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Ascending entries, always ready.
    for (int k = 0; k < N; k++) vals[k] = k + 1;
    pack();
    out_ready = 1'b1;
    pulse_start();
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_data", out_data, 1);
    chk("t1_first_idx", out_idx, 0);
    run_to_done(40);
    chk("t1_beats", beats.size(), 16);
    for (int k = 0; k < N; k++) chk("t1_order", beats[k], k + 1);
    chk("t1_peak_val", peak_val, PEAK ? 16 : 0);
    chk("t1_peak_idx", peak_idx, PEAK ? 15 : 0);
    tick();
    chk("t1_idle", busy, 0);

    // Ready toggling every cycle.
    pulse_start();
    begin
      int n = 0;
      while (done !== 1'b1 && n < 80) begin
        out_ready = ~out_ready;
        tick(); n++;
      end
    end
    chk("t2_done", done, 1);
    chk("t2_beats", beats.size(), 16);
    for (int k = 0; k < N; k++) chk("t2_order", beats[k], k + 1);
    out_ready = 1'b1;
    tick();

    // Two saturated entries: tie resolves to the lower index.
    for (int k = 0; k < N; k++) vals[k] = 0;
    vals[3] = 511; vals[9] = 511;
    pack();
    pulse_start();
    run_to_done(40);
    chk("t3_beat3", beats[3], 511);
    chk("t3_beat9", beats[9], 511);
    chk("t3_peak_val", peak_val, PEAK ? 511 : 0);
    chk("t3_peak_idx", peak_idx, PEAK ? 3 : 0);
    tick();

    // Flush after five transfers.
    for (int k = 0; k < N; k++) vals[k] = $urandom_range(0, 511);
    pack();
    pulse_start();
    begin
      int n = 0;
      while (beats.size() < 5 && n < 40) begin tick(); n++; end
    end
    chk("t4_five", beats.size(), 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_pvalid", peak_valid, 0);
    for (int i = 0; i < 3; i++) begin tick(); chk("t4_no_done", done, 0); end

    // Asynchronous reset mid-scan, then rescan.
    pulse_start();
    begin
      int n = 0;
      while (out_idx !== IW'(7) && n < 40) begin tick(); n++; end
    end
    chk("t5_at7", out_idx, 7);
    rst = 1'b1;
    #1;
    model_reset();
    check_zero("t5_rst");
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    chk("t5_restart_idx", out_idx, 0);
    chk("t5_restart_data", out_data, vals[0]);
    run_to_done(40);
    tick();

    // Matrix change and start re-pulse mid-scan are ignored.
    for (int k = 0; k < N; k++) vals[k] = k + 1;
    pack();
    pulse_start();
    tick(); tick(); tick();
    for (int k = 0; k < N; k++) vals[k] = 500 - k;
    pack();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(40);
    chk("t6_beats", beats.size(), 16);
    for (int k = 0; k < N; k++) chk("t6_orig", beats[k], k + 1);

    // Back-to-back: start held through DONE is taken in the following IDLE cycle.
    start = 1'b1;
    tick();
    chk("t7_idle", busy, 0);
    tick();
    start = 1'b0;
    chk("t7_restart", out_valid, 1);
    chk("t7_restart_data", out_data, 500);
    run_to_done(40);
    tick();

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < N; k++)
        vals[k] = ($urandom_range(0, 7) == 0) ? 511 : $urandom_range(0, 511);
      pack();
      pulse_start();
      begin
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
          out_ready = ($urandom_range(0, 3) != 0);
          start = ($urandom_range(0, 9) == 0);
          flush = ($urandom_range(0, 79) == 0);
          if ($urandom_range(0, 9) == 0) begin
            for (int k = 0; k < N; k++) vals[k] = $urandom_range(0, 511);
            pack();
          end
          tick(); n++;
        end
      end
      start = 1'b0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
